instr_fetch_responder: RTL and testbench

//  Instruction-memory responder: the other end of the program-counter fetch interface.

---
 rtl/instr_fetch_responder_if.sv | 28 ++
 rtl/instr_fetch_responder.sv | 116 +++++++++++
 tb/tb_instr_fetch_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_responder_if.sv
// Fetch/response/load bus between the PC side (master) and the instruction responder (slave).
interface instr_fetch_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_instr;
   logic [ADDR_W-1:0] rsp_addr;
   logic              rsp_err;
   logic              ld_en;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              busy;

   modport master (
      output req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready, ld_en, ld_addr, ld_data,
      output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err, busy
   );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction memory responder: in-order fetch responses after a fixed read pipeline,
// with an output FIFO sized so that every accepted request always has a slot.
module instr_fetch_responder #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input logic                   clk,
   input logic                   rst,
   instr_fetch_responder_if.slave bus
);
   localparam int FDEPTH = LATENCY + 1;
   localparam int PTR_W  = $clog2(FDEPTH);
   localparam int OCC_W  = $clog2(FDEPTH + 1);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] addr;
      logic              err;
   } rsp_t;

   logic [DATA_W-1:0] mem [DEPTH];
   rsp_t              fifo [FDEPTH];
   rsp_t              rd_ent, push_ent, head;
   logic              rd_oor, ld_oor;
   logic              rdy, acc, push, pop, rsp_vld;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [OCC_W-1:0]  fcnt, occ;

   generate
      if (DEPTH == 2**ADDR_W) begin : g_full_range
         assign rd_oor = 1'b0;
         assign ld_oor = 1'b0;
      end else begin : g_part_range
         assign rd_oor = (bus.req_addr >= ADDR_W'(DEPTH));
         assign ld_oor = (bus.ld_addr  >= ADDR_W'(DEPTH));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (bus.ld_en && !ld_oor) mem[bus.ld_addr[IDX_W-1:0]] <= bus.ld_data;
   end

   assign rdy = !rst && !bus.ld_en && (occ < OCC_W'(FDEPTH));
   assign acc = bus.req_valid && rdy;

   always_comb begin
      rd_ent.instr = rd_oor ? '0 : mem[bus.req_addr[IDX_W-1:0]];
      rd_ent.addr  = bus.req_addr;
      rd_ent.err   = rd_oor;
   end

   // The acceptance edge captures the read, so LATENCY-1 more register stages remain before the FIFO.
   generate
      if (LATENCY == 1) begin : g_direct
         assign push     = acc;
         assign push_ent = rd_ent;
      end else begin : g_pipe
         rsp_t                pipe [LATENCY-1];
         logic [LATENCY-2:0]  vld_pipe;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               vld_pipe <= '0;
            end else begin
               vld_pipe[0] <= acc;
               for (int k = 1; k < LATENCY-1; k++) vld_pipe[k] <= vld_pipe[k-1];
            end
         end

         always_ff @(posedge clk) begin
            pipe[0] <= rd_ent;
            for (int k = 1; k < LATENCY-1; k++) pipe[k] <= pipe[k-1];
         end

         assign push     = vld_pipe[LATENCY-2];
         assign push_ent = pipe[LATENCY-2];
      end
   endgenerate

   function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FDEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign rsp_vld = (fcnt != '0);
   assign pop     = rsp_vld && bus.rsp_ready;
   assign head    = fifo[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fcnt   <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= nxt(wr_ptr);
         if (pop)  rd_ptr <= nxt(rd_ptr);
         fcnt <= fcnt + OCC_W'(push) - OCC_W'(pop);
         occ  <= occ  + OCC_W'(acc)  - OCC_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= push_ent;
   end

   // Masking with valid keeps the outputs at zero out of reset without resetting FIFO storage.
   assign bus.req_ready = rdy;
   assign bus.rsp_valid = rsp_vld;
   assign bus.rsp_instr = rsp_vld ? head.instr : '0;
   assign bus.rsp_addr  = rsp_vld ? head.addr  : '0;
   assign bus.rsp_err   = rsp_vld & head.err;
   assign bus.busy      = (occ != '0);
endmodule

// File: tb/tb_instr_fetch_responder.sv
// Randomised bench for instr_fetch_responder against a queue-based reference model.
module tb_instr_fetch_responder;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int DEP = 16;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   instr_fetch_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [DW-1:0] instr;
      logic [AW-1:0] addr;
      logic          err;
      int            due;
   } exp_t;

   exp_t          q[$];
   logic [DW-1:0] mmem [DEP];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   // One bus cycle: drive, check outputs against the model, then advance the model.
   task automatic step(input logic rv, input logic [AW-1:0] ra, input logic rr,
                       input logic le = 1'b0, input logic [AW-1:0] la = '0,
                       input logic [DW-1:0] ld = '0);
      bit   exp_rdy, exp_vld;
      exp_t e;
      @(negedge clk);
      bus.req_valid = rv;
      bus.req_addr  = ra;
      bus.rsp_ready = rr;
      bus.ld_en     = le;
      bus.ld_addr   = la;
      bus.ld_data   = ld;
      #1;
      exp_rdy = !le && (q.size() < LAT + 1);
      exp_vld = (q.size() > 0) && (q[0].due <= cyc);
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("rsp_valid", bus.rsp_valid, exp_vld);
      chk("busy", bus.busy, q.size() != 0);
      if (exp_vld) begin
         chk("rsp_instr", bus.rsp_instr, q[0].instr);
         chk("rsp_addr",  bus.rsp_addr,  q[0].addr);
         chk("rsp_err",   bus.rsp_err,   q[0].err);
      end
      if (exp_vld && rr) void'(q.pop_front());
      if (rv && exp_rdy) begin
         e.addr  = ra;
         e.err   = (ra >= DEP);
         e.instr = e.err ? '0 : mmem[ra[3:0]];
         e.due   = cyc + LAT;
         q.push_back(e);
      end
      if (le && la < DEP) mmem[la[3:0]] = ld;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
   endtask

   initial begin
      logic [DW-1:0] prog [4];
      logic          rv, rr, le;
      logic [AW-1:0] ra, la;
      logic [DW-1:0] ld;
      prog[0] = 32'h20080005; prog[1] = 32'h20090007;
      prog[2] = 32'h01095020; prog[3] = 32'h08000000;

      bus.req_valid = 1'b0; bus.req_addr = '0; bus.rsp_ready = 1'b0;
      bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk("reset_busy",      bus.busy,      1'b0);
      chk("reset_req_ready", bus.req_ready, 1'b0);
      chk("reset_rsp_instr", bus.rsp_instr, '0);
      chk("reset_rsp_addr",  bus.rsp_addr,  '0);
      chk("reset_rsp_err",   bus.rsp_err,   1'b0);
      @(negedge clk);
      rst = 1'b0;

      // program load then back-to-back fetch
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, AW'(i), prog[i]);
      for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 1'b1);
      idle(4);

      // stalled consumer: only LAT+1 requests get in, outputs hold while stalled
      for (int i = 0; i < 6; i++) step(1'b1, AW'(3 - (i % 4)), 1'b0);
      idle(6);

      // load wins over a simultaneous request; next-cycle fetch sees new data
      step(1'b1, 8'd5, 1'b1, 1'b1, 8'd5, 32'hCAFEF00D);
      step(1'b1, 8'd5, 1'b1);
      idle(3);

      // out-of-range request sandwiched between valid ones
      step(1'b1, 8'd1, 1'b1);
      step(1'b1, 8'h20, 1'b1);
      step(1'b1, 8'd2, 1'b1);
      idle(4);

      // reset with two requests in flight
      step(1'b1, 8'd0, 1'b0);
      step(1'b1, 8'd1, 1'b0);
      @(negedge clk);
      bus.req_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("midrst_busy",      bus.busy,      1'b0);
      chk("midrst_req_ready", bus.req_ready, 1'b0);
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'd2, 1'b1);
      step(1'b1, 8'd5, 1'b1);
      idle(4);

      // fill the rest of memory, then random traffic with occasional loads
      for (int i = 4; i < DEP; i++) step(1'b0, '0, 1'b1, 1'b1, AW'(i), DW'($urandom));
      for (int i = 0; i < 1000; i++) begin
         rv = ($urandom_range(0, 9) < 7);
         ra = AW'($urandom_range(0, DEP + 3));
         rr = ($urandom_range(0, 9) < 6);
         le = ($urandom_range(0, 19) == 0);
         la = AW'($urandom_range(0, DEP - 1));
         ld = DW'($urandom);
         step(rv, ra, rr, le, la, ld);
      end
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
